// File: rtl/crc_seq.sv
// Purpose: byte-to-bit sequencer driving an external serial CRC-8 engine; optional CRC_SEQ_CHECK_EN adds out_match (zero-residue check).
// Latency: last byte accepted at T -> out_valid at T+10, or T+11 when that byte also opened the frame (extra INIT cycle).
// Backpressure: in_ready only in IDLE without abort; result held in DONE until out_ready; abort overrides everything.
module crc_seq #(
    parameter int MSB_FIRST = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       abort,
    output logic       crc_init,
    output logic       crc_step,
    output logic       crc_bit,
    input  logic [7:0] crc_value,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_crc,
`ifdef CRC_SEQ_CHECK_EN
    output logic       out_match,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SHIFT  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       sof_q;
    logic [2:0] cnt_q;
    logic [7:0] data_q;
    logic       last_q;
    logic       accept;
    logic [2:0] bit_sel;

    // Bit counter maps to a byte index; MSB-first walks 7..0, LSB-first walks 0..7.
    assign bit_sel = (MSB_FIRST != 0) ? ~cnt_q : cnt_q;
    assign busy    = (state_q != IDLE);

`ifdef CRC_SEQ_CHECK_EN
    // Zero residue means the frame carried its own correct CRC.
    assign out_match = out_valid && (out_crc == 8'h00);
`endif

    // Next-state and strobe decode; abort wins over every other input.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        accept    = 1'b0;
        crc_init  = 1'b0;
        crc_step  = 1'b0;
        crc_bit   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // reset term keeps in_ready low while reset is held
                in_ready = reset && !abort;
                if (in_valid && reset && !abort) begin
                    accept  = 1'b1;
                    state_d = sof_q ? INIT : SHIFT;
                end
            end
            INIT: begin
                crc_init = 1'b1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                crc_step = 1'b1;
                crc_bit  = data_q[bit_sel];
                if (cnt_q == 3'd7) begin
                    state_d = last_q ? SETTLE : IDLE;
                end
            end
            SETTLE: begin
                // engine register has absorbed the 8th bit by now
                state_d = DONE;
            end
            DONE: begin
                // an abort in DONE drops the result, so it is not offered
                out_valid = !abort;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // State, frame bookkeeping, bit counter and result capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sof_q   <= 1'b1;
            cnt_q   <= 3'd0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            out_crc <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= in_data;
                last_q <= in_last;
            end
            if (abort) begin
                sof_q <= 1'b1;
                cnt_q <= 3'd0;
            end else begin
                if (state_q == INIT) begin
                    sof_q <= 1'b0;
                end
                if (state_q == DONE && out_ready) begin
                    sof_q <= 1'b1;
                end
                if (state_q == SHIFT) begin
                    cnt_q <= cnt_q + 3'd1;
                end
                if (state_q == SETTLE) begin
                    out_crc <= crc_value;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_seq.sv
// Bench for crc_seq with a serial CRC-8 engine attached and a polynomial-division reference.
// Stimulus driven 1ns after the rising edge, outputs sampled on the falling edge.
// Every wait is bounded; a global watchdog stops a runaway simulation.
`timescale 1ns/1ps
module tb_crc_seq;

    localparam int MSB = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] crc_value;
    logic       in_ready, crc_init, crc_step, crc_bit, out_valid, busy;
    logic [7:0] out_crc;
`ifdef CRC_SEQ_CHECK_EN
    logic       out_match;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int init_cnt = 0;
    int overlap_cnt = 0;
    int stray_cnt = 0;
    logic [7:0] eng = 8'h00;
    bit bits_q[$];

    crc_seq #(.MSB_FIRST(MSB)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .abort    (abort),
        .crc_init (crc_init),
        .crc_step (crc_step),
        .crc_bit  (crc_bit),
        .crc_value(crc_value),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_crc  (out_crc),
`ifdef CRC_SEQ_CHECK_EN
        .out_match(out_match),
`endif
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Serial CRC-8 engine, poly x^8+x^5+x^4+1
    always @(posedge clock) begin
        if (crc_init) eng <= 8'h00;
        else if (crc_step) eng <= {eng[6:0], 1'b0} ^ (((eng[7] ^ crc_bit) != 1'b0) ? 8'h31 : 8'h00);
    end
    assign crc_value = eng;

    // Strobe monitor
    always @(negedge clock) begin
        if (crc_init) init_cnt <= init_cnt + 1;
        if (crc_step) bits_q.push_back(crc_bit);
        if (crc_init && crc_step) overlap_cnt <= overlap_cnt + 1;
        if ((crc_init || crc_step) && !busy) stray_cnt <= stray_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference: remainder of message(x) * x^8 modulo 0x131, bits in serial order.
    function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
        logic [8:0] r;
        bit b;
        r = 9'h000;
        for (int i = 0; i <= msg.size(); i++) begin
            for (int j = 0; j < 8; j++) begin
                if (i < msg.size()) b = (MSB != 0) ? msg[i][7-j] : msg[i][j];
                else b = 1'b0;
                r = {r[7:0], b};
                if (r[8]) r = r ^ 9'h131;
            end
        end
        return r[7:0];
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int t, output bit ok);
        ok = 1'b0;
        t = -1;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (in_ready) begin
                t = cyc;
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_valid(output int t, output bit ok);
        ok = 1'b0;
        t = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (out_valid) begin
                t = cyc;
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_frame(input logic [7:0] msg[$], input int hold, output logic [7:0] crc,
                             output int lat, output bit held_ok, output bit ok);
        int t, tv;
        bit a, v;
        ok = 1'b1;
        held_ok = 1'b1;
        lat = -1;
        crc = 8'h00;
        t = 0;
        foreach (msg[i]) begin
            send_byte(msg[i], (i == msg.size() - 1), t, a);
            if (!a) ok = 1'b0;
        end
        wait_valid(tv, v);
        if (!v) begin
            ok = 1'b0;
            return;
        end
        lat = tv - t;
        crc = out_crc;
        for (int k = 0; k < hold; k++) begin
            tick();
            @(negedge clock);
            if (!out_valid || out_crc !== crc) held_ok = 1'b0;
        end
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (crc_init !== 1'b0 || crc_step !== 1'b0 || crc_bit !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b%b want 000", crc_init, crc_step, crc_bit); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: got %b%b want 00", out_valid, busy); end
        checks++; if (out_crc !== 8'h00) begin errors++; $display("FAIL reset_out_crc: got %h want 00", out_crc); end
`ifdef CRC_SEQ_CHECK_EN
        checks++; if (out_match !== 1'b0) begin errors++; $display("FAIL reset_out_match: got %b want 0", out_match); end
`endif
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_single_a5;
        logic [7:0] msg[$];
        logic [7:0] crc;
        int lat, i0;
        bit held, ok;
        bit exp_bits[8];
        exp_bits = '{1, 0, 1, 0, 0, 1, 0, 1};
        msg = {8'hA5};
        bits_q.delete();
        i0 = init_cnt;
        run_frame(msg, 0, crc, lat, held, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL a5_handshake: got %b want 1", ok); end
        checks++; if (init_cnt - i0 != 1) begin errors++; $display("FAIL a5_init_pulses: got %0d want 1", init_cnt - i0); end
        checks++; if (bits_q.size() != 8) begin errors++; $display("FAIL a5_step_count: got %0d want 8", bits_q.size()); end
        for (int k = 0; k < 8 && k < bits_q.size(); k++) begin
            checks++; if (bits_q[k] !== exp_bits[k]) begin errors++; $display("FAIL a5_bit%0d: got %b want %b", k, bits_q[k], exp_bits[k]); end
        end
        checks++; if (crc !== ref_crc(msg)) begin errors++; $display("FAIL a5_crc: got %h want %h", crc, ref_crc(msg)); end
    endtask

    task automatic test_latency_hold;
        logic [7:0] msg[$];
        logic [7:0] crc;
        int lat;
        bit held, ok;
        msg = {8'h80};
        run_frame(msg, 3, crc, lat, held, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lat_handshake: got %b want 1", ok); end
        checks++; if (lat != 11) begin errors++; $display("FAIL lat_first_byte: got %0d want 11", lat); end
        checks++; if (crc !== 8'h7A) begin errors++; $display("FAIL lat_crc_80: got %h want 7a", crc); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL lat_hold_stable: got %b want 1", held); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL lat_release: got valid %b ready %b want 0 1", out_valid, in_ready); end
        tick();
    endtask

    task automatic test_residue;
        logic [7:0] msg[$];
        logic [7:0] crc;
        int lat;
        bit held, ok, m;
        msg = {8'h80, 8'h7A};
        run_frame(msg, 1, crc, lat, held, ok);
        checks++; if (ok !== 1'b1 || crc !== 8'h00) begin errors++; $display("FAIL residue_good_crc: got %h ok %b want 00 ok 1", crc, ok); end
        checks++; if (lat != 10) begin errors++; $display("FAIL residue_latency: got %0d want 10", lat); end
        msg = {8'h80, 8'h7B};
        send_byte(msg[0], 1'b0, lat, ok);
        send_byte(msg[1], 1'b1, lat, ok);
        wait_valid(lat, ok);
        checks++; if (ok !== 1'b1 || out_crc !== ref_crc(msg)) begin errors++; $display("FAIL residue_bad_crc: got %h want %h", out_crc, ref_crc(msg)); end
`ifdef CRC_SEQ_CHECK_EN
        checks++; if (out_match !== 1'b0) begin errors++; $display("FAIL residue_bad_match: got %b want 0", out_match); end
`endif
        m = (out_crc == 8'h00);
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL residue_bad_nonzero: got %h want nonzero", out_crc); end
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random_frames;
        logic [7:0] msg[$];
        logic [7:0] crc;
        int lat, i0, len, bad;
        bit held, ok;
        for (int f = 0; f < 6; f++) begin
            msg.delete();
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) msg.push_back(8'($urandom));
            bits_q.delete();
            i0 = init_cnt;
            run_frame(msg, $urandom_range(0, 2), crc, lat, held, ok);
            checks++; if (ok !== 1'b1 || crc !== ref_crc(msg)) begin errors++; $display("FAIL rand%0d_crc: got %h want %h", f, crc, ref_crc(msg)); end
            checks++; if (lat != ((len == 1) ? 11 : 10)) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", f, lat, (len == 1) ? 11 : 10); end
            checks++; if (init_cnt - i0 != 1) begin errors++; $display("FAIL rand%0d_init: got %0d want 1", f, init_cnt - i0); end
            bad = (bits_q.size() != 8 * len) ? 1 : 0;
            for (int k = 0; k < 8 * len && k < bits_q.size(); k++)
                if (bits_q[k] !== ((MSB != 0) ? msg[k/8][7-(k%8)] : msg[k/8][k%8])) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_bits: got %0d bad of %0d want 0", f, bad, bits_q.size()); end
        end
    endtask

    task automatic test_abort_shift;
        logic [7:0] msg[$];
        logic [7:0] crc;
        int t, lat, i0, seen;
        bit ok, held;
        send_byte(8'h11, 1'b0, t, ok);
        send_byte(8'h22, 1'b1, t, ok);
        tick(); tick(); tick();
        @(negedge clock);
        checks++; if (crc_step !== 1'b1 || cyc != t + 4) begin errors++; $display("FAIL abort_shift_pos: got step %b cycle %0d want 1 %0d", crc_step, cyc, t + 4); end
        tick();
        abort = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_shift_ready: got %b want 0", in_ready); end
        tick();
        abort = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_shift_idle: got busy %b ready %b want 0 1", busy, in_ready); end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            @(negedge clock);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_shift_no_valid: got %0d valid cycles want 0", seen); end
        tick();
        msg = {8'h80};
        i0 = init_cnt;
        run_frame(msg, 0, crc, lat, held, ok);
        checks++; if (init_cnt - i0 != 1 || crc !== 8'h7A || lat != 11) begin errors++; $display("FAIL abort_shift_next: got init %0d crc %h lat %0d want 1 7a 11", init_cnt - i0, crc, lat); end
    endtask

    task automatic test_abort_done;
        logic [7:0] msg[$];
        logic [7:0] crc;
        int t, lat;
        bit ok, held;
        send_byte(8'h33, 1'b1, t, ok);
        wait_valid(t, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_done_reach: got %b want 1", ok); end
        tick();
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_done_drop: got %b want 0", out_valid); end
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_done_idle: got ready %b busy %b valid %b want 1 0 0", in_ready, busy, out_valid); end
        tick();
        msg = {8'h80};
        run_frame(msg, 0, crc, lat, held, ok);
        checks++; if (lat != 11 || crc !== 8'h7A) begin errors++; $display("FAIL abort_done_next: got lat %0d crc %h want 11 7a", lat, crc); end
    endtask

    task automatic test_reset_back_to_back;
        int t, i0, acc, bad, exp_acc, c;
        bit ok, first;
        send_byte(8'h5A, 1'b1, t, ok);
        wait_valid(t, ok);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL async_reset_outputs: got valid %b busy %b ready %b want 0 0 0", out_valid, busy, in_ready); end
        checks++; if (out_crc !== 8'h00) begin errors++; $display("FAIL async_reset_crc: got %h want 00", out_crc); end
        tick();
        reset = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b0;
        in_data = 8'($urandom);
        i0 = init_cnt;
        acc = 0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (in_ready !== !busy) bad++;
            if (in_ready && in_valid) acc++;
            tick();
            in_data = 8'($urandom);
        end
        in_valid = 1'b0;
        // first byte: IDLE+INIT+8 SHIFT, later bytes: IDLE+8 SHIFT
        exp_acc = 0;
        c = 0;
        first = 1'b1;
        while (c < 40) begin
            exp_acc++;
            c += first ? 10 : 9;
            first = 1'b0;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ready_idle_only: got %0d bad cycles want 0", bad); end
        checks++; if (acc != exp_acc) begin errors++; $display("FAIL b2b_accepts: got %0d want %0d", acc, exp_acc); end
        checks++; if (init_cnt - i0 != 1) begin errors++; $display("FAIL b2b_init: got %0d want 1", init_cnt - i0); end
        for (int k = 0; k < 20 && busy; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_single_a5();
        test_latency_hold();
        test_residue();
        test_random_frames();
        test_abort_shift();
        test_abort_done();
        test_reset_back_to_back();
        tick();
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL init_step_overlap: got %0d want 0", overlap_cnt); end
        checks++; if (stray_cnt != 0) begin errors++; $display("FAIL strobe_outside_frame: got %0d want 0", stray_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
